mgmt_wb_arbiter: RTL and testbench
==================================

// Module: mgmt_wb_arbiter
// PURPOSE
//  Shares the management SoC's exported Wishbone port between two masters:
//  m0 = CPU data bus and m1 = debug/UART bridge.
//  Routes each transaction to the user-project slave (mprj_*) or the housekeeping slave (hk_*) by address decode.
//  Guards every access with a timeout watchdog that returns an error instead of hanging the core.
//  Sits inside the management core, in front of the mprj/hk ports of the core wrapper.
// PARAMETERS
//  TIMEOUT_W       8              width of the watchdog counter
//  TIMEOUT_CYCLES  255            cycles without slave ack before abort (<= 2**TIMEOUT_W-1)
//  MPRJ_BASE       32'h3000_0000  user-project region base
//  MPRJ_MASK       32'hF000_0000  compare mask for MPRJ_BASE
//  HK_BASE         32'h2600_0000  housekeeping region base
//  HK_MASK         32'hFF00_0000  compare mask for HK_BASE
// PORTS
//  core_clk      in   1   single clock; all logic rising-edge
//  core_rst      in   1   reset: synchronous, active-high
//  mN_cyc_i      in   1   master N cycle (N=0,1)
//  mN_stb_i      in   1   master N strobe
//  mN_we_i       in   1   master N write enable
//  mN_sel_i      in   4   master N byte selects
//  mN_adr_i      in   32  master N address
//  mN_dat_i      in   32  master N write data
//  mN_ack_o      out  1   master N ack, 1-cycle pulse
//  mN_err_o      out  1   master N error (unmapped or timeout), 1-cycle pulse
//  mN_dat_o      out  32  master N read data, valid with ack
//  mprj_cyc_o    out  1   user-project cycle
//  mprj_stb_o    out  1   user-project strobe
//  mprj_we_o     out  1   shared write enable (mprj and hk)
//  mprj_sel_o    out  4   shared byte selects
//  mprj_adr_o    out  32  shared address
//  mprj_dat_o    out  32  shared write data
//  mprj_ack_i    in   1   user-project ack
//  mprj_dat_i    in   32  user-project read data
//  mprj_wb_iena  out  1   enables user return path; high only while an mprj access is in flight
//  hk_cyc_o      out  1   housekeeping cycle
//  hk_stb_o      out  1   housekeeping strobe
//  hk_ack_i      in   1   housekeeping ack
//  hk_dat_i      in   32  housekeeping read data
//  timeout_o     out  1   1-cycle pulse when the watchdog aborts an access
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, watchdog=0, round-robin pointer favours m0.
//  FSM states:
//   IDLE  - sample requests (cyc&stb). Both request: grant the master not granted last; else the single requester.
//           Register grant, target, adr/we/sel/dat. Go to BUSY, or to RESP with err if the address hits neither region.
//           mprj decode has priority over hk if both regions match.
//   BUSY  - assert target cyc/stb (mprj_wb_iena=1 for mprj); watchdog increments each cycle.
//           Target ack -> latch read data, go to RESP.
//           Watchdog == TIMEOUT_CYCLES -> go to RESP with err and pulse timeout_o.
//           Granted master drops cyc -> abort: go to IDLE, no ack/err.
//   RESP  - slave cyc/stb low; pulse ack (or err) plus dat_o to the granted master only; clear watchdog; go to IDLE.
//  Latency: request in IDLE at cycle 0; slave stb at cycle 1; slave ack at cycle k gives master ack at cycle k+1.
//           Unmapped access gives err at cycle 2.
//  Ack and err are never both high.
//  Ungranted master's ack/err stay 0; it simply waits.
//  m0/m1 outputs: dat_o holds its last value, meaningful only with ack.
//  A slave ack arriving outside BUSY, or from the non-selected slave, is ignored.
//  Shared adr/we/sel/dat outputs are held stable for the whole BUSY phase.
//  Reset mid-transaction: next edge returns to the reset state; in-flight access dropped without ack.
//  Watchdog saturates; it cannot wrap within one access.
// STRUCTURE
//  Package mgmt_wb_pkg: FSM state enum (IDLE/BUSY/RESP), target enum (NONE/MPRJ/HK), default address-map constants.
//  Sub-module mgmt_wb_rr_arb: 2-way round-robin; req[1:0], advance -> gnt onehot, last-grant pointer.
//  Top holds the FSM, decode, watchdog and the output muxes.
// TESTING
//  1. m0 read 0x3000_0004, mprj acks at cycle 3 with 0xDEAD_BEEF
//     -> mprj_stb_o cycles 1-3, m0_ack_o at cycle 4, m0_dat_o=0xDEAD_BEEF, mprj_wb_iena only cycles 1-3.
//  2. m0 and m1 request together twice
//     -> grants m0 then m1; a third simultaneous pair grants m0 again.
//  3. m1 write 0x2600_0010 data 0x1, hk acks at cycle 2
//     -> hk_stb_o high, mprj_stb_o low, mprj_dat_o=0x1, m1_ack_o at cycle 3.
//  4. m0 access 0x1000_0000 (unmapped)
//     -> m0_err_o at cycle 2, no slave cyc ever asserted.
//  5. mprj never acks
//     -> m0_err_o and timeout_o pulse at cycle TIMEOUT_CYCLES+2 (257 default); a late mprj ack is ignored.
//  6. core_rst=1 during BUSY, or m0 drops cyc mid-access
//     -> outputs 0 next cycle, no ack/err, next m0 request served normally.

Source files
------------

// File: rtl/mgmt_wb_arbiter_pkg.sv
// Shared types and default address map for the management Wishbone arbiter.
package mgmt_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_MPRJ = 2'd1,
    TGT_HK   = 2'd2
  } target_t;

  localparam logic [31:0] DEF_MPRJ_BASE = 32'h3000_0000;
  localparam logic [31:0] DEF_MPRJ_MASK = 32'hF000_0000;
  localparam logic [31:0] DEF_HK_BASE   = 32'h2600_0000;
  localparam logic [31:0] DEF_HK_MASK   = 32'hFF00_0000;

  // User-project region wins when both windows match.
  function automatic target_t decode(input logic [31:0] adr,
                                     input logic [31:0] mprj_base,
                                     input logic [31:0] mprj_mask,
                                     input logic [31:0] hk_base,
                                     input logic [31:0] hk_mask);
    if ((adr & mprj_mask) == (mprj_base & mprj_mask)) return TGT_MPRJ;
    if ((adr & hk_mask) == (hk_base & hk_mask)) return TGT_HK;
    return TGT_NONE;
  endfunction

endpackage

// File: rtl/mgmt_wb_arbiter_if.sv
// One Wishbone master port as seen by the arbiter.
// Handshake: a request is cyc&stb held with stable adr/we/sel/dat_w until a
// single-cycle ack or err; dat_r is valid only with ack. Dropping cyc aborts.
interface mgmt_wb_arbiter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic        ack;
  logic        err;
  logic [31:0] dat_r;

  modport master (output cyc, stb, we, sel, adr, dat_w, input ack, err, dat_r);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, err, dat_r);
endinterface

// File: rtl/mgmt_wb_arbiter_rr_arb.sv
// Two-way round-robin arbiter; the pointer records which master won last.
module mgmt_wb_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 means m1 was granted last, so reset leaves m0 favoured.
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mgmt_wb_arbiter.sv
// Arbitrates two Wishbone masters onto the user-project and housekeeping
// slaves with address decode and a per-access timeout watchdog.
module mgmt_wb_arbiter
  import mgmt_wb_pkg::*;
#(
  parameter int          TIMEOUT_W      = 8,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] MPRJ_BASE      = DEF_MPRJ_BASE,
  parameter logic [31:0] MPRJ_MASK      = DEF_MPRJ_MASK,
  parameter logic [31:0] HK_BASE        = DEF_HK_BASE,
  parameter logic [31:0] HK_MASK        = DEF_HK_MASK
) (
  input  logic             core_clk,
  input  logic             core_rst,
  mgmt_wb_arbiter_if.slave m0,
  mgmt_wb_arbiter_if.slave m1,
  output logic             mprj_cyc_o,
  output logic             mprj_stb_o,
  output logic             mprj_we_o,
  output logic [3:0]       mprj_sel_o,
  output logic [31:0]      mprj_adr_o,
  output logic [31:0]      mprj_dat_o,
  input  logic             mprj_ack_i,
  input  logic [31:0]      mprj_dat_i,
  output logic             mprj_wb_iena,
  output logic             hk_cyc_o,
  output logic             hk_stb_o,
  input  logic             hk_ack_i,
  input  logic [31:0]      hk_dat_i,
  output logic             timeout_o,
  output state_t           state_dbg
);

  state_t                 state_q, state_d;
  target_t                tgt_q;
  logic                   gnt_q;          // 1 = m1 owns the current access
  logic                   we_q;
  logic [3:0]             sel_q;
  logic [31:0]            adr_q, dat_q, rdata_q;
  logic                   err_q, to_q;
  logic [TIMEOUT_W-1:0]   wd_q;

  logic [1:0]             req, gnt;
  logic                   cur_cyc, sel_ack, wd_hit, busy, resp;

  assign req     = {m1.cyc & m1.stb, m0.cyc & m0.stb};
  assign cur_cyc = gnt_q ? m1.cyc : m0.cyc;
  assign sel_ack = ((tgt_q == TGT_MPRJ) && mprj_ack_i) || ((tgt_q == TGT_HK) && hk_ack_i);
  assign wd_hit  = (wd_q == TIMEOUT_W'(TIMEOUT_CYCLES));

  mgmt_wb_rr_arb u_rr_arb (
    .clk     (core_clk),
    .rst     (core_rst),
    .req     (req),
    .advance (state_q == ST_IDLE),
    .gnt     (gnt)
  );

  always_ff @(posedge core_clk) begin
    if (core_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Unmapped accesses pass through one BUSY cycle with no slave selected so
  // the error reaches the master with the same two-cycle latency as a hit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req != 2'b00) state_d = ST_BUSY;
      ST_BUSY: begin
        if (!cur_cyc)                                  state_d = ST_IDLE;
        else if ((tgt_q == TGT_NONE) || sel_ack || wd_hit) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      tgt_q   <= TGT_NONE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wd_q <= '0;
          if (gnt != 2'b00) begin
            gnt_q <= gnt[1];
            we_q  <= gnt[1] ? m1.we    : m0.we;
            sel_q <= gnt[1] ? m1.sel   : m0.sel;
            adr_q <= gnt[1] ? m1.adr   : m0.adr;
            dat_q <= gnt[1] ? m1.dat_w : m0.dat_w;
            tgt_q <= decode(gnt[1] ? m1.adr : m0.adr, MPRJ_BASE, MPRJ_MASK, HK_BASE, HK_MASK);
            err_q <= 1'b0;
            to_q  <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (wd_q != {TIMEOUT_W{1'b1}}) wd_q <= wd_q + 1'b1;
          if (sel_ack) begin
            rdata_q <= (tgt_q == TGT_MPRJ) ? mprj_dat_i : hk_dat_i;
          end else if (tgt_q == TGT_NONE) begin
            err_q <= 1'b1;
          end else if (wd_hit) begin
            err_q <= 1'b1;
            to_q  <= 1'b1;
          end
        end
        default: wd_q <= '0;
      endcase
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign resp = (state_q == ST_RESP);

  always_comb begin
    mprj_cyc_o   = busy && (tgt_q == TGT_MPRJ);
    mprj_stb_o   = busy && (tgt_q == TGT_MPRJ);
    mprj_wb_iena = busy && (tgt_q == TGT_MPRJ);
    hk_cyc_o     = busy && (tgt_q == TGT_HK);
    hk_stb_o     = busy && (tgt_q == TGT_HK);
    mprj_we_o    = busy && we_q;
    mprj_sel_o   = busy ? sel_q : 4'h0;
    mprj_adr_o   = busy ? adr_q : 32'h0;
    mprj_dat_o   = busy ? dat_q : 32'h0;
    timeout_o    = resp && to_q;
    state_dbg    = state_q;
  end

  assign m0.ack   = resp && !err_q && !gnt_q;
  assign m0.err   = resp &&  err_q && !gnt_q;
  assign m1.ack   = resp && !err_q &&  gnt_q;
  assign m1.err   = resp &&  err_q &&  gnt_q;
  assign m0.dat_r = rdata_q;
  assign m1.dat_r = rdata_q;

endmodule

// File: tb/tb_mgmt_wb_arbiter.sv
// Directed bench for mgmt_wb_arbiter: response scoreboard plus cycle-exact checks.
module tb_mgmt_wb_arbiter;
  import mgmt_wb_pkg::*;

  logic        core_clk;
  logic        core_rst;
  logic        mprj_cyc_o, mprj_stb_o, mprj_we_o, mprj_wb_iena;
  logic [3:0]  mprj_sel_o;
  logic [31:0] mprj_adr_o, mprj_dat_o, mprj_dat_i, hk_dat_i;
  logic        mprj_ack_i, hk_ack_i, hk_cyc_o, hk_stb_o, timeout_o;
  state_t      state_dbg;

  mgmt_wb_arbiter_if m0_if ();
  mgmt_wb_arbiter_if m1_if ();

  mgmt_wb_arbiter dut (
    .core_clk     (core_clk),
    .core_rst     (core_rst),
    .m0           (m0_if),
    .m1           (m1_if),
    .mprj_cyc_o   (mprj_cyc_o),
    .mprj_stb_o   (mprj_stb_o),
    .mprj_we_o    (mprj_we_o),
    .mprj_sel_o   (mprj_sel_o),
    .mprj_adr_o   (mprj_adr_o),
    .mprj_dat_o   (mprj_dat_o),
    .mprj_ack_i   (mprj_ack_i),
    .mprj_dat_i   (mprj_dat_i),
    .mprj_wb_iena (mprj_wb_iena),
    .hk_cyc_o     (hk_cyc_o),
    .hk_stb_o     (hk_stb_o),
    .hk_ack_i     (hk_ack_i),
    .hk_dat_i     (hk_dat_i),
    .timeout_o    (timeout_o),
    .state_dbg    (state_dbg)
  );

  // Clock and reset
  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entry: {master, err, data}
  logic [33:0] exp_q[$];
  logic [33:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic set_req(input bit m, input bit we, input logic [31:0] adr, input logic [31:0] dat);
    if (!m) begin
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = we;
      m0_if.sel = 4'hF; m0_if.adr = adr; m0_if.dat_w = dat;
    end else begin
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = we;
      m1_if.sel = 4'hF; m1_if.adr = adr; m1_if.dat_w = dat;
    end
  endtask

  task automatic drop(input bit m);
    if (!m) begin m0_if.cyc = 1'b0; m0_if.stb = 1'b0; end
    else    begin m1_if.cyc = 1'b0; m1_if.stb = 1'b0; end
  endtask

  // Called at the negedge of the cycle in which the request is sampled (cycle 0).
  // The selected slave acks in cycle ack_at; the master sees ack in ack_at+1.
  task automatic serve(input bit m, input bit is_mprj, input bit we, input logic [31:0] adr,
                       input logic [31:0] wdat, input int ack_at, input logic [31:0] rd,
                       input bit stray);
    exp_q.push_back({m, 1'b0, rd});
    for (int t = 1; t <= ack_at + 1; t++) begin
      @(negedge core_clk);
      if (t <= ack_at) begin
        chk("busy_mprj_stb", 32'(mprj_stb_o), 32'(is_mprj));
        chk("busy_hk_stb", 32'(hk_stb_o), 32'(!is_mprj));
        chk("busy_iena", 32'(mprj_wb_iena), 32'(is_mprj));
        chk("busy_adr", mprj_adr_o, adr);
        chk("busy_we", 32'(mprj_we_o), 32'(we));
        if (we) chk("busy_wdat", mprj_dat_o, wdat);
        if (stray && t == 1) begin
          if (is_mprj) hk_ack_i = 1'b1; else mprj_ack_i = 1'b1;
        end
        if (stray && t == 2) begin
          hk_ack_i = 1'b0; mprj_ack_i = 1'b0;
        end
        if (t == ack_at) begin
          if (is_mprj) begin mprj_ack_i = 1'b1; mprj_dat_i = rd; end
          else begin hk_ack_i = 1'b1; hk_dat_i = rd; end
        end
      end else begin
        chk("resp_stb_low", 32'(mprj_stb_o | hk_stb_o), 32'd0);
        chk("resp_iena_low", 32'(mprj_wb_iena), 32'd0);
        chk("resp_ack", 32'(m ? m1_if.ack : m0_if.ack), 32'd1);
        mprj_ack_i = 1'b0;
        hk_ack_i   = 1'b0;
        drop(m);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    chk({tag, "_cyc"}, 32'({mprj_cyc_o, mprj_stb_o, hk_cyc_o, hk_stb_o, mprj_wb_iena}), 32'd0);
    chk({tag, "_acks"}, 32'({m0_if.ack, m0_if.err, m1_if.ack, m1_if.err, timeout_o}), 32'd0);
    chk({tag, "_adr"}, mprj_adr_o, 32'd0);
  endtask

  // Monitor: every master response pops the scoreboard.
  always @(negedge core_clk) begin
    if (m0_if.ack | m0_if.err | m1_if.ack | m1_if.err) begin
      chk("ack_err_exclusive",
          32'((m0_if.ack & m0_if.err) | (m1_if.ack & m1_if.err) |
              ((m0_if.ack | m0_if.err) & (m1_if.ack | m1_if.err))), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got m0 ack/err=%b%b m1 ack/err=%b%b expected none at %0t",
                 m0_if.ack, m0_if.err, m1_if.ack, m1_if.err, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_master", 32'(m1_if.ack | m1_if.err), 32'(mon_e[33]));
        chk("resp_err", 32'(m0_if.err | m1_if.err), 32'(mon_e[32]));
        if (!mon_e[32]) chk("resp_data", m1_if.ack ? m1_if.dat_r : m0_if.dat_r, mon_e[31:0]);
      end
    end
  end

  task automatic pulse_reset();
    core_rst = 1'b1;
    repeat (2) @(negedge core_clk);
    check_idle_outputs("reset");
    core_rst = 1'b0;
  endtask

  initial begin
    core_rst   = 1'b1;
    mprj_ack_i = 1'b0; hk_ack_i = 1'b0;
    mprj_dat_i = 32'h0; hk_dat_i = 32'h0;
    drop(0); drop(1);
    m0_if.we = 1'b0; m0_if.sel = 4'h0; m0_if.adr = 32'h0; m0_if.dat_w = 32'h0;
    m1_if.we = 1'b0; m1_if.sel = 4'h0; m1_if.adr = 32'h0; m1_if.dat_w = 32'h0;
    pulse_reset();

    // 1: m0 read from mprj, ack at cycle 3, stray hk ack during BUSY
    @(negedge core_clk);
    set_req(0, 1'b0, 32'h3000_0004, 32'h0);
    chk("t1_stb_c0", 32'(mprj_stb_o), 32'd0);
    serve(0, 1'b1, 1'b0, 32'h3000_0004, 32'h0, 3, 32'hDEAD_BEEF, 1'b1);
    @(negedge core_clk);
    chk("t1_iena_after", 32'(mprj_wb_iena), 32'd0);
    pulse_reset();

    // 2: round-robin across three simultaneous pairs
    @(negedge core_clk);
    set_req(0, 1'b0, 32'h3000_0100, 32'h0);
    set_req(1, 1'b0, 32'h3000_0200, 32'h0);
    serve(0, 1'b1, 1'b0, 32'h3000_0100, 32'h0, 1, 32'hA0A0_0001, 1'b0);
    @(negedge core_clk);
    set_req(0, 1'b0, 32'h3000_0300, 32'h0);
    serve(1, 1'b1, 1'b0, 32'h3000_0200, 32'h0, 2, 32'hA0A0_0002, 1'b0);
    @(negedge core_clk);
    set_req(1, 1'b0, 32'h3000_0400, 32'h0);
    serve(0, 1'b1, 1'b0, 32'h3000_0300, 32'h0, 1, 32'hA0A0_0003, 1'b0);
    @(negedge core_clk);
    serve(1, 1'b1, 1'b0, 32'h3000_0400, 32'h0, 1, 32'hA0A0_0004, 1'b0);

    // 3: m1 write to housekeeping, ack at cycle 2
    @(negedge core_clk);
    set_req(1, 1'b1, 32'h2600_0010, 32'h0000_0001);
    serve(1, 1'b0, 1'b1, 32'h2600_0010, 32'h0000_0001, 2, 32'h0000_0055, 1'b0);

    // 4: unmapped address errors at cycle 2 without touching a slave
    @(negedge core_clk);
    set_req(0, 1'b0, 32'h1000_0000, 32'h0);
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    @(negedge core_clk);
    chk("t4_cyc_c1", 32'({mprj_cyc_o, hk_cyc_o}), 32'd0);
    chk("t4_err_c1", 32'(m0_if.err), 32'd0);
    @(negedge core_clk);
    chk("t4_cyc_c2", 32'({mprj_cyc_o, hk_cyc_o}), 32'd0);
    chk("t4_err_c2", 32'(m0_if.err), 32'd1);
    drop(0);

    // 5: mprj never acks; watchdog aborts at cycle 257, late ack ignored
    @(negedge core_clk);
    set_req(0, 1'b0, 32'h3000_0008, 32'h0);
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    for (int t = 1; t <= 259; t++) begin
      @(negedge core_clk);
      if (t == 1 || t == 256) begin
        chk("t5_stb_held", 32'(mprj_stb_o), 32'd1);
        chk("t5_no_timeout", 32'(timeout_o), 32'd0);
      end
      if (t == 257) begin
        chk("t5_timeout_pulse", 32'(timeout_o), 32'd1);
        chk("t5_err", 32'(m0_if.err), 32'd1);
        chk("t5_stb_low", 32'(mprj_stb_o), 32'd0);
        mprj_ack_i = 1'b1;
        mprj_dat_i = 32'hBAD0_BAD0;
        drop(0);
      end
      if (t == 258) begin
        chk("t5_timeout_once", 32'(timeout_o), 32'd0);
        chk("t5_late_ack_ignored", 32'(m0_if.ack), 32'd0);
      end
      if (t == 259) begin
        chk("t5_idle", 32'(state_dbg), 32'(ST_IDLE));
        mprj_ack_i = 1'b0;
      end
    end

    // 6a: reset during BUSY drops the access, next request served normally
    @(negedge core_clk);
    set_req(0, 1'b0, 32'h3000_000C, 32'h0);
    @(negedge core_clk);
    chk("t6a_stb_c1", 32'(mprj_stb_o), 32'd1);
    @(negedge core_clk);
    core_rst = 1'b1;
    @(negedge core_clk);
    check_idle_outputs("t6a");
    core_rst = 1'b0;
    drop(0);
    @(negedge core_clk);
    set_req(0, 1'b0, 32'h3000_0010, 32'h0);
    serve(0, 1'b1, 1'b0, 32'h3000_0010, 32'h0, 1, 32'hCAFE_0001, 1'b0);

    // 6b: m0 drops cyc mid-access, stray ack afterwards is ignored
    @(negedge core_clk);
    set_req(0, 1'b0, 32'h3000_0014, 32'h0);
    @(negedge core_clk);
    chk("t6b_stb_c1", 32'(mprj_stb_o), 32'd1);
    @(negedge core_clk);
    drop(0);
    @(negedge core_clk);
    check_idle_outputs("t6b");
    mprj_ack_i = 1'b1;
    @(negedge core_clk);
    mprj_ack_i = 1'b0;
    chk("t6b_no_ack", 32'({m0_if.ack, m0_if.err}), 32'd0);
    set_req(0, 1'b0, 32'h2600_0020, 32'h0);
    serve(0, 1'b0, 1'b0, 32'h2600_0020, 32'h0, 1, 32'h1234_5678, 1'b0);

    repeat (3) @(negedge core_clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
